// File: rtl/riscv_pkg.sv
// Shared execute-stage definitions: load_control encodings, load FSM states
// and the byte-offset width used by the load path.
package riscv_pkg;

    localparam int unsigned BYTE_OFF_W = 2;
    localparam int unsigned LD_CTRL_W  = 3;

    localparam logic [LD_CTRL_W-1:0] LD_NOP = 3'd0;
    localparam logic [LD_CTRL_W-1:0] LB     = 3'd1;
    localparam logic [LD_CTRL_W-1:0] LH     = 3'd2;
    localparam logic [LD_CTRL_W-1:0] LW     = 3'd3;
    localparam logic [LD_CTRL_W-1:0] LBU    = 3'd4;
    localparam logic [LD_CTRL_W-1:0] LHU    = 3'd5;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_WAIT = 2'd1,
        LD_WB   = 2'd2
    } ld_state_e;

    // Codes 0, 6 and 7 are no-ops.
    function automatic logic is_load(input logic [LD_CTRL_W-1:0] ctrl);
        return (ctrl >= LB) && (ctrl <= LHU);
    endfunction

endpackage

// File: rtl/load_extract.sv
// Purely combinational load data extraction: selects byte/half/word from a
// memory word by byte offset and sign- or zero-extends it to 32 bits.
module load_extract
    import riscv_pkg::*;
(
    input  logic [31:0]           word,
    input  logic [BYTE_OFF_W-1:0] off,
    input  logic [LD_CTRL_W-1:0]  ctrl,
    output logic [31:0]           result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'(word >> {off, 3'b000});
        // Halfword select ignores off[0]; misaligned halves truncate.
        half_v = off[1] ? word[31:16] : word[15:0];
        result = '0;
        case (ctrl)
            LB:      result = {{24{byte_v[7]}}, byte_v};
            LBU:     result = {24'd0, byte_v};
            LH:      result = {{16{half_v[15]}}, half_v};
            LHU:     result = {16'd0, half_v};
            LW:      result = word;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Execute-stage load unit: effective address, fixed-latency word read,
// extraction and one-cycle register write-back, stalling fetch/execute meanwhile.
// Optional misaligned-load trap enabled by defining LOAD_MISALIGN_TRAP_EN.
module load_unit
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_RD_LATENCY = 1,
    parameter int unsigned ADDR_W         = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [31:0]          rs1_val,
    input  logic [31:0]          imm,
    input  logic [2:0]           load_control,
    input  logic [4:0]           rd_idx,
    input  logic [31:0]          mem_read_data,
    output logic                 stall_pc,
    output logic                 stall_other_exec,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 rd_wr_en,
    output logic [4:0]           rd_wr_idx,
    output logic [31:0]          rd_wr_data,
    output logic                 load_misalign
);

    localparam int unsigned EA_W  = ADDR_W + BYTE_OFF_W;
    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_RD_LATENCY - 1);

    ld_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BYTE_OFF_W-1:0] off_q;
    logic [LD_CTRL_W-1:0]  ctrl_q;
    logic [4:0]            idx_q;
    logic [31:0]           data_q;
    logic                  mis_q;
    logic [EA_W-1:0]       ea;
    logic                  issue;
    logic                  capture;
    logic                  mis_c;
    logic [31:0]           ext_data;

    // Upper address bits are dropped, so the data memory wraps.
    assign ea = EA_W'(rs1_val + imm);

`ifdef LOAD_MISALIGN_TRAP_EN
    always_comb begin
        mis_c = 1'b0;
        if (load_control == LW) begin
            mis_c = (ea[1:0] != 2'b00);
        end else if ((load_control == LH) || (load_control == LHU)) begin
            mis_c = ea[0];
        end
    end
`else
    assign mis_c = 1'b0;
`endif

    load_extract u_extract (
        .word   (data_q),
        .off    (off_q),
        .ctrl   (ctrl_q),
        .result (ext_data)
    );

    // State, counter and request latches; reset abandons any load in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= LD_IDLE;
            cnt_q   <= '0;
            off_q   <= '0;
            ctrl_q  <= LD_NOP;
            idx_q   <= '0;
            data_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (issue) begin
                off_q  <= ea[BYTE_OFF_W-1:0];
                ctrl_q <= load_control;
                idx_q  <= rd_idx;
                mis_q  <= mis_c;
            end
            if (capture) begin
                data_q <= mem_read_data;
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        issue            = 1'b0;
        capture          = 1'b0;
        stall_pc         = 1'b0;
        stall_other_exec = 1'b0;
        mem_rd_en        = 1'b0;
        mem_addr         = '0;
        rd_wr_en         = 1'b0;
        rd_wr_idx        = '0;
        rd_wr_data       = '0;
        load_misalign    = 1'b0;
        case (state_q)
            LD_IDLE: begin
                if (is_load(load_control)) begin
                    issue     = 1'b1;
                    mem_rd_en = 1'b1;
                    mem_addr  = ea[EA_W-1:BYTE_OFF_W];
                    stall_pc  = 1'b1;
                    cnt_d     = CNT_LOAD;
                    state_d   = LD_WAIT;
                end
            end
            LD_WAIT: begin
                stall_pc         = 1'b1;
                stall_other_exec = 1'b1;
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = LD_WB;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LD_WB: begin
                rd_wr_en      = ~mis_q;
                load_misalign = mis_q;
                rd_wr_idx     = idx_q;
                rd_wr_data    = ext_data;
                state_d       = LD_IDLE;
            end
            default: state_d = LD_IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: two instances (read latency 1 and 3),
// directed vector table, reset/toggle corner sequences, randomized loads.
module tb_load_unit;
    import riscv_pkg::*;

    localparam int unsigned ADDR_W = 10;
`ifdef LOAD_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef struct packed {
        logic              stall;
        logic              soe;
        logic              rden;
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [4:0]        idx;
        logic [31:0]       data;
        logic              mis;
    } obs_t;

    typedef struct {
        int          d;
        string       tag;
        logic [2:0]  c;
        logic [31:0] r;
        logic [31:0] i;
        logic [4:0]  rd;
        logic [31:0] word;
        logic [9:0]  waddr;
        logic [31:0] e_data;
        bit          mis;
        int          noise;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0]       rs1_val       [2];
    logic [31:0]       imm           [2];
    logic [2:0]        load_control  [2];
    logic [4:0]        rd_idx        [2];
    logic [31:0]       mem_read_data [2];
    logic              stall_pc      [2];
    logic              stall_other_exec [2];
    logic              mem_rd_en     [2];
    logic [ADDR_W-1:0] mem_addr      [2];
    logic              rd_wr_en      [2];
    logic [4:0]        rd_wr_idx     [2];
    logic [31:0]       rd_wr_data    [2];
    logic              load_misalign [2];

    logic [31:0]       mem [1024];
    logic [ADDR_W-1:0] ap  [2][4];
    logic              vp  [2][4];

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    load_unit #(.MEM_RD_LATENCY(1), .ADDR_W(ADDR_W)) u_dut_l1 (
        .i_clk(clk), .i_rst(rst), .rs1_val(rs1_val[0]), .imm(imm[0]),
        .load_control(load_control[0]), .rd_idx(rd_idx[0]),
        .mem_read_data(mem_read_data[0]), .stall_pc(stall_pc[0]),
        .stall_other_exec(stall_other_exec[0]), .mem_rd_en(mem_rd_en[0]),
        .mem_addr(mem_addr[0]), .rd_wr_en(rd_wr_en[0]), .rd_wr_idx(rd_wr_idx[0]),
        .rd_wr_data(rd_wr_data[0]), .load_misalign(load_misalign[0])
    );

    load_unit #(.MEM_RD_LATENCY(3), .ADDR_W(ADDR_W)) u_dut_l3 (
        .i_clk(clk), .i_rst(rst), .rs1_val(rs1_val[1]), .imm(imm[1]),
        .load_control(load_control[1]), .rd_idx(rd_idx[1]),
        .mem_read_data(mem_read_data[1]), .stall_pc(stall_pc[1]),
        .stall_other_exec(stall_other_exec[1]), .mem_rd_en(mem_rd_en[1]),
        .mem_addr(mem_addr[1]), .rd_wr_en(rd_wr_en[1]), .rd_wr_idx(rd_wr_idx[1]),
        .rd_wr_data(rd_wr_data[1]), .load_misalign(load_misalign[1])
    );

    // Memory model: data valid exactly LATENCY cycles after the read strobe, garbage otherwise.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int s = 3; s > 0; s--) begin
                ap[d][s] <= ap[d][s-1];
                vp[d][s] <= vp[d][s-1];
            end
            ap[d][0] <= mem_addr[d];
            vp[d][0] <= mem_rd_en[d];
        end
    end
    assign mem_read_data[0] = (vp[0][0] === 1'b1) ? mem[ap[0][0]] : 32'hDEAD_BEEF;
    assign mem_read_data[1] = (vp[1][2] === 1'b1) ? mem[ap[1][2]] : 32'hDEAD_BEEF;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Reference extraction from the ISA rules using plain arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] c, input logic [31:0] w,
                                             input int unsigned off);
        int unsigned b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (off >= 2) ? (w >> 16) : (w & 32'hFFFF);
        case (c)
            LB:      return 32'((b >= 128) ? b - 256 : b);
            LBU:     return 32'(b);
            LH:      return 32'((h >= 32768) ? h - 65536 : h);
            LHU:     return 32'(h);
            LW:      return w;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit ref_mis(input logic [2:0] c, input logic [31:0] ea);
        return ((c == LW) && ((ea % 4) != 0)) || (((c == LH) || (c == LHU)) && ((ea % 2) != 0));
    endfunction

    function automatic obs_t mk(input logic s, input logic o, input logic re,
                                input logic [ADDR_W-1:0] a, input logic w,
                                input logic [4:0] ix, input logic [31:0] dt, input logic m);
        obs_t e;
        e = '{stall: s, soe: o, rden: re, addr: a, wr: w, idx: ix, data: dt, mis: m};
        return e;
    endfunction

    function automatic obs_t get_obs(input int d);
        return mk(stall_pc[d], stall_other_exec[d], mem_rd_en[d], mem_addr[d],
                  rd_wr_en[d], rd_wr_idx[d], rd_wr_data[d], load_misalign[d]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    endtask

    task automatic drive(input int d, input logic [2:0] c, input logic [31:0] r,
                         input logic [31:0] i, input logic [4:0] rd);
        load_control[d] = c;
        rs1_val[d]      = r;
        imm[d]          = i;
        rd_idx[d]       = rd;
    endtask

    // Samples at the falling edge; idx/data/addr compared when relevant or when full is set.
    task automatic expect_cycle(input int d, input string tag, input obs_t e, input bit full);
        obs_t a;
        @(negedge clk);
        a = get_obs(d);
        check({tag, ".stall_pc"},      32'(a.stall), 32'(e.stall));
        check({tag, ".stall_other"},   32'(a.soe),   32'(e.soe));
        check({tag, ".mem_rd_en"},     32'(a.rden),  32'(e.rden));
        check({tag, ".rd_wr_en"},      32'(a.wr),    32'(e.wr));
        check({tag, ".load_misalign"}, 32'(a.mis),   32'(e.mis));
        if (full || e.rden) check({tag, ".mem_addr"}, 32'(a.addr), 32'(e.addr));
        if (full || e.wr) begin
            check({tag, ".rd_wr_idx"},  32'(a.idx), 32'(e.idx));
            check({tag, ".rd_wr_data"}, a.data, e.data);
        end
    endtask

    // Full load sequence from issue to write-back; called just after a rising edge.
    task automatic run_load(input int d, input string tag, input logic [2:0] c,
                            input logic [31:0] r, input logic [31:0] i, input logic [4:0] rd,
                            input logic [ADDR_W-1:0] e_addr, input logic [31:0] e_data,
                            input bit e_mis, input int noise);
        drive(d, c, r, i, rd);
        expect_cycle(d, {tag, "@issue"}, mk(1, 0, 1, e_addr, 0, 0, 0, 0), 1'b0);
        @(posedge clk); #1;
        for (int k = 1; k <= lat_of(d); k++) begin
            if (noise != 0) drive(d, LW, $urandom, $urandom, 5'($urandom));
            else drive(d, LD_NOP, 0, 0, 0);
            expect_cycle(d, {tag, "@wait"}, mk(1, 1, 0, 0, 0, 0, 0, 0), 1'b0);
            @(posedge clk); #1;
        end
        if (noise != 0) drive(d, 3'($urandom_range(1, 5)), $urandom, $urandom, 5'($urandom));
        else drive(d, LD_NOP, 0, 0, 0);
        expect_cycle(d, {tag, "@wb"}, mk(0, 0, 0, 0, !e_mis, rd, e_data, e_mis), 1'b0);
        @(posedge clk); #1;
        drive(d, LD_NOP, 0, 0, 0);
    endtask

    // Reset in the first wait cycle: stalls drop after the edge and no write ever appears.
    task automatic reset_mid(input int d);
        mem[10'h040] = 32'h80AA_55CC;
        drive(d, LB, 32'h100, 32'd3, 5'd7);
        expect_cycle(d, "rst@issue", mk(1, 0, 1, 10'h040, 0, 0, 0, 0), 1'b0);
        @(posedge clk); #1;
        drive(d, LD_NOP, 0, 0, 0);
        rst = 1'b1;
        expect_cycle(d, "rst@wait", mk(1, 1, 0, 0, 0, 0, 0, 0), 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < lat_of(d) + 3; k++) begin
            expect_cycle(d, "rst@after", mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vec_t        vt [$];
        logic [2:0]  c;
        logic [31:0] r, i, w, ea;
        logic [4:0]  rd;
        bit          em;

        vt.push_back('{0, "lb",     LB,  32'h100, 32'd3, 5'd5,  32'h80AA55CC, 10'h040, 32'hFFFFFF80, 1'b0, 0});
        vt.push_back('{0, "lbu",    LBU, 32'h100, 32'd3, 5'd6,  32'h80AA55CC, 10'h040, 32'h00000080, 1'b0, 0});
        vt.push_back('{0, "lhu2",   LHU, 32'h100, 32'd2, 5'd7,  32'h80AA55CC, 10'h040, 32'h000080AA, 1'b0, 0});
        vt.push_back('{0, "lh0",    LH,  32'h100, 32'd0, 5'd8,  32'h80AA55CC, 10'h040, 32'h000055CC, 1'b0, 0});
        vt.push_back('{0, "lh2",    LH,  32'h100, 32'd2, 5'd9,  32'h80AA55CC, 10'h040, 32'hFFFF80AA, 1'b0, 0});
        vt.push_back('{0, "lb1",    LB,  32'h100, 32'd1, 5'd10, 32'h80AA55CC, 10'h040, 32'h00000055, 1'b0, 0});
        vt.push_back('{0, "lbu0",   LBU, 32'h100, 32'd0, 5'd11, 32'h80AA55CC, 10'h040, 32'h000000CC, 1'b0, 0});
        vt.push_back('{0, "lhu3",   LHU, 32'h100, 32'd3, 5'd12, 32'h80AA55CC, 10'h040, 32'h000080AA, 1'b1, 0});
        vt.push_back('{0, "lw_mis", LW,  32'h100, 32'd2, 5'd13, 32'h80AA55CC, 10'h040, 32'h80AA55CC, 1'b1, 0});
        vt.push_back('{0, "lw_x0",  LW,  32'h100, 32'd0, 5'd0,  32'h80AA55CC, 10'h040, 32'h80AA55CC, 1'b0, 0});
        vt.push_back('{0, "wrap",   LB,  32'h1100, 32'd3, 5'd14, 32'h80AA55CC, 10'h040, 32'hFFFFFF80, 1'b0, 0});
        vt.push_back('{0, "toggle", LB,  32'h100, 32'd3, 5'd15, 32'h80AA55CC, 10'h040, 32'hFFFFFF80, 1'b0, 1});
        vt.push_back('{1, "lw_l3",  LW,  32'hFFFFFFFC, 32'd8, 5'd16, 32'h12345678, 10'h001, 32'h12345678, 1'b0, 0});
        vt.push_back('{1, "lh_l3",  LH,  32'h100, 32'd0, 5'd17, 32'h00008001, 10'h040, 32'hFFFF8001, 1'b0, 1});

        rst = 1'b1;
        drive(0, LD_NOP, 0, 0, 0);
        drive(1, LD_NOP, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        expect_cycle(0, "reset0", mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        expect_cycle(1, "reset1", mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        expect_cycle(0, "idle0", mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        expect_cycle(1, "idle1", mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        @(posedge clk); #1;

        foreach (vt[k]) begin
            mem[vt[k].waddr] = vt[k].word;
            run_load(vt[k].d, vt[k].tag, vt[k].c, vt[k].r, vt[k].i, vt[k].rd,
                     vt[k].waddr, vt[k].e_data, TRAP_EN && vt[k].mis, vt[k].noise);
        end

        reset_mid(0);
        reset_mid(1);

        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 80; n++) begin
                c  = 3'($urandom_range(0, 7));
                r  = $urandom;
                i  = $urandom;
                rd = 5'($urandom);
                ea = r + i;
                if (is_load(c)) begin
                    w = $urandom;
                    mem[ADDR_W'(ea >> 2)] = w;
                    em = TRAP_EN && ref_mis(c, ea);
                    run_load(d, "rand", c, r, i, rd, ADDR_W'(ea >> 2),
                             ref_load(c, w, ea % 4), em, int'($urandom_range(0, 1)));
                end else begin
                    drive(d, c, r, i, rd);
                    expect_cycle(d, "rand_nop", mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
                    @(posedge clk); #1;
                    drive(d, LD_NOP, 0, 0, 0);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
